// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pipe_pkg
//  Description : Shared MIPS pipeline types and constants (NOP encoding,
//                default datapath widths, IF/ID entry record).
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    localparam int PC_W_DEFAULT    = 32;
    localparam int INSTR_W_DEFAULT = 32;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0]    pc;
        logic [INSTR_W_DEFAULT-1:0] instr;
    } if_id_entry_t;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/if_id_entry_ram.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_entry_ram
//  Description : DEPTH x WIDTH register array, one synchronous write port and
//                one combinational read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_entry_ram #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : if_id_entry_ram
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer
//  Description : In-order valid/ready queue between fetch and decode with
//                flush. Optional statistics under IF_ID_BUFFER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [$clog2(DEPTH):0] count
`ifdef IF_ID_BUFFER_STATS_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            flushed_entries
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + INSTR_W;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_rd_data;

    // Ready is a function of registered occupancy only, so a full queue
    // refuses a push even while decode is draining it.
    assign w_in_ready  = (r_count < CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid  & w_in_ready  & ~flush;
    assign w_pop       = w_out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    if_id_entry_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data ({in_pc, in_instr}),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign count     = r_count;
    assign out_pc    = w_out_valid ? w_rd_data[EW-1:INSTR_W]   : '0;
    assign out_instr = w_out_valid ? w_rd_data[INSTR_W-1:0]    : INSTR_W'(INSTR_NOP);

`ifdef IF_ID_BUFFER_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flushed_entries;
    logic [32:0] w_flush_sum;

    assign w_flush_sum = {1'b0, r_flushed_entries} + 33'(r_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles    <= '0;
            r_flushed_entries <= '0;
        end else begin
            if (in_valid && !w_in_ready && !flush && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (flush) begin
                r_flushed_entries <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
            end
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign flushed_entries = r_flushed_entries;
`endif

endmodule : if_id_buffer
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_buffer
//  Description : Self-checking bench for if_id_buffer (DEPTH=2): directed
//                vector table, stats sequence, randomized queue-model run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;
    import mips_pipe_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  count;
`ifdef IF_ID_BUFFER_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flushed_entries;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_id_buffer #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
`ifdef IF_ID_BUFFER_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flushed_entries (flushed_entries)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return (pc == 32'h0) ? 32'h2008_0005 : {16'h2400, pc[15:0]};
    endfunction

    typedef struct {
        logic        rst, in_valid, flush, out_ready;
        logic [31:0] pc;
        logic [1:0]  e_count;
        logic        e_ov, e_ir;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, iv, input logic [31:0] pc, input logic fl, ordy,
                                input logic [1:0] ec, input logic eov, eir, input logic [31:0] epc);
        vec_t v;
        v.rst = r; v.in_valid = iv; v.pc = pc; v.flush = fl; v.out_ready = ordy;
        v.e_count = ec; v.e_ov = eov; v.e_ir = eir; v.e_pc = epc;
        v.e_instr = eov ? ins_of(epc) : INSTR_NOP;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, iv, input logic [31:0] pc, input logic fl, ordy);
        rst = r; in_valid = iv; in_pc = pc; in_instr = ins_of(pc); flush = fl; out_ready = ordy;
    endtask

    // Behavioural reference: a plain queue of entries plus counters.
    if_id_entry_t model_q[$];
    logic [31:0]  m_stall;
    logic [31:0]  m_flushed;

    task automatic model_step();
        bit full;
        full = (model_q.size() >= DEPTH);
        if (!rst) begin
            if (in_valid && full && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (flush) m_flushed = m_flushed + model_q.size();
        end else begin
            m_stall = 0;
            m_flushed = 0;
        end
        if (rst || flush) begin
            model_q.delete();
        end else begin
            bit do_pop;
            do_pop = (model_q.size() != 0) && out_ready;
            if (do_pop) void'(model_q.pop_front());
            if (in_valid && !full) model_q.push_back('{pc: in_pc, instr: in_instr});
        end
    endtask

    task automatic check_model();
        int sz;
        sz = model_q.size();
        chk("rnd_count", 32'(count), 32'(sz));
        chk("rnd_in_ready", 32'(in_ready), 32'(sz < DEPTH));
        chk("rnd_out_valid", 32'(out_valid), 32'(sz != 0));
        chk("rnd_out_pc", out_pc, (sz != 0) ? model_q[0].pc : 32'h0);
        chk("rnd_out_instr", out_instr, (sz != 0) ? model_q[0].instr : INSTR_NOP);
`ifdef IF_ID_BUFFER_STATS_EN
        chk("rnd_stall_cycles", stall_cycles, m_stall);
        chk("rnd_flushed_entries", flushed_entries, m_flushed);
`endif
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // reset, single push/pop, full back-pressure, push+pop wrap, flush, mid-stream reset
        add(1, 0, 32'h0,  0, 0, 0, 0, 1, 32'h0);
        add(1, 0, 32'h0,  0, 0, 0, 0, 1, 32'h0);
        add(0, 1, 32'h0,  0, 0, 1, 1, 1, 32'h0);
        add(0, 0, 32'h0,  0, 1, 0, 0, 1, 32'h0);
        add(0, 1, 32'h4,  0, 0, 1, 1, 1, 32'h4);
        add(0, 1, 32'h8,  0, 0, 2, 1, 0, 32'h4);
        add(0, 1, 32'hC,  0, 0, 2, 1, 0, 32'h4);
        add(0, 1, 32'hC,  0, 1, 1, 1, 1, 32'h8);
        add(0, 1, 32'hC,  0, 1, 1, 1, 1, 32'hC);
        add(0, 0, 32'h0,  0, 1, 0, 0, 1, 32'h0);
        add(0, 1, 32'h100, 0, 0, 1, 1, 1, 32'h100);
        for (int k = 0; k < 8; k++) begin
            add(0, 1, 32'h104 + 32'(4 * k), 0, 1, 1, 1, 1, 32'h104 + 32'(4 * k));
        end
        add(0, 1, 32'h200, 0, 0, 2, 1, 0, 32'h120);
        add(0, 1, 32'h40,  1, 1, 0, 0, 1, 32'h0);
        add(0, 0, 32'h0,   0, 1, 0, 0, 1, 32'h0);
        add(0, 1, 32'h300, 0, 0, 1, 1, 1, 32'h300);
        add(1, 1, 32'h304, 0, 1, 0, 0, 1, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].in_valid, vecs[i].pc, vecs[i].flush, vecs[i].out_ready);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_out_instr", i), out_instr, vecs[i].e_instr);
        end

`ifdef IF_ID_BUFFER_STATS_EN
        // two fills, three stalled offers, flush at count=2, then reset
        @(negedge clk); drive(1, 0, 32'h0, 0, 0);
        @(negedge clk); drive(0, 1, 32'h10, 0, 0);
        @(negedge clk); drive(0, 1, 32'h14, 0, 0);
        repeat (3) begin @(negedge clk); drive(0, 1, 32'h18, 0, 0); end
        @(negedge clk); drive(0, 1, 32'h18, 1, 0);
        @(negedge clk); drive(0, 0, 32'h0, 0, 0);
        #1;
        chk("stats_stall_cycles", stall_cycles, 32'd3);
        chk("stats_flushed_entries", flushed_entries, 32'd2);
        drive(1, 0, 32'h0, 0, 0);
        @(negedge clk); drive(0, 0, 32'h0, 0, 0);
        #1;
        chk("stats_stall_after_rst", stall_cycles, 32'd0);
        chk("stats_flushed_after_rst", flushed_entries, 32'd0);
`endif

        // randomized run against the queue model, starting from reset
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 0);
        model_q.delete();
        m_stall = 0;
        m_flushed = 0;
        model_step();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] pc;
            @(negedge clk);
            check_model();
            pc = {$urandom_range(0, 16'hFFFF), 14'h0, 2'b00};
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), pc,
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
            model_step();
        end
        @(negedge clk);
        check_model();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_if_id_buffer
`default_nettype wire
